// File: rtl/dcache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_fill_ctrl
// Description : Miss handling for a small data cache. On an all-line miss it
//               picks the line with the smallest TTL as victim, issues a
//               one-hot fill command, re-issues it if the line does not
//               respond, and counts serviced misses. A free-running counter
//               broadcasts a periodic TTL aging pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_fill_ctrl #(
  parameter int NLINES    = 4,
  parameter int TTLBITS   = 8,
  parameter int AGEPERIOD = 256
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        dcache_rdreq,
  input  logic                        dcache_wrreq,
  input  logic [NLINES-1:0]           line_miss,
  input  logic [NLINES*TTLBITS-1:0]   line_ttl,
  input  logic [NLINES-1:0]           line_busy,
  output logic [NLINES-1:0]           fill_req,
  output logic                        cache_hit,
  output logic                        cache_stall,
  output logic                        age_tick,
  output logic [15:0]                 miss_cnt
);

  localparam int              c_VID_W    = (NLINES > 1) ? $clog2(NLINES) : 1;
  localparam int              c_AGE_W    = $clog2(AGEPERIOD);
  localparam logic [3:0]      c_TMO_LAST = 4'd14;  // counter steps to 15 on this cycle
  localparam logic [NLINES-1:0] c_ONE    = NLINES'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_GRANT     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [c_VID_W-1:0]   victim_q, victim_d;
  logic [3:0]           tmo_q, tmo_d;
  logic [15:0]          miss_cnt_q, miss_cnt_d;
  logic [c_AGE_W-1:0]   age_q;

  logic                 w_req;
  logic                 w_allmiss;
  logic [c_VID_W-1:0]   w_min_idx;
  logic [TTLBITS-1:0]   w_min_ttl;

  assign w_req     = dcache_rdreq | dcache_wrreq;
  assign w_allmiss = &line_miss;
  assign miss_cnt  = miss_cnt_q;
  assign age_tick  = (age_q == c_AGE_W'(AGEPERIOD - 1));

  // Smallest-TTL search; strict less-than keeps the lowest index on ties.
  always_comb begin
    w_min_idx = '0;
    w_min_ttl = line_ttl[0 +: TTLBITS];
    for (int i = 1; i < NLINES; i++) begin
      if (line_ttl[i*TTLBITS +: TTLBITS] < w_min_ttl) begin
        w_min_ttl = line_ttl[i*TTLBITS +: TTLBITS];
        w_min_idx = c_VID_W'(i);
      end
    end
  end

  // Next-state and output decode; only the victim's busy bit is ever looked at.
  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    tmo_d       = tmo_q;
    miss_cnt_d  = miss_cnt_q;
    fill_req    = '0;
    cache_hit   = 1'b0;
    cache_stall = 1'b1;
    case (state_q)
      S_IDLE: begin
        cache_hit   = w_req & ~w_allmiss;
        cache_stall = w_req & w_allmiss;
        if (w_req && w_allmiss) begin
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        victim_d = w_min_idx;
        state_d  = S_GRANT;
      end
      S_GRANT: begin
        fill_req = c_ONE << victim_q;
        tmo_d    = '0;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (line_busy[victim_q]) begin
          state_d = S_WAIT_DONE;
        end else begin
          tmo_d = tmo_q + 4'd1;
          if (tmo_q == c_TMO_LAST) begin
            state_d = S_GRANT;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!line_busy[victim_q]) begin
          state_d = S_IDLE;
          if (miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM, victim, timeout and miss-count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      victim_q   <= '0;
      tmo_q      <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      tmo_q      <= tmo_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Free-running aging counter, wraps every AGEPERIOD cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      age_q <= '0;
    end else if (age_q == c_AGE_W'(AGEPERIOD - 1)) begin
      age_q <= '0;
    end else begin
      age_q <= age_q + c_AGE_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_fill_ctrl
// Description : Self-checking bench for dcache_fill_ctrl with a behavioural
//               model of victim choice, fill timing and miss counting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_fill_ctrl;

  localparam int NL = 4;
  localparam int TW = 8;
  localparam int AP = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [NL-1:0] line_miss = '0;
  logic [NL*TW-1:0] ttl = '0;
  logic [NL-1:0] busy = '0;
  logic [NL-1:0] fill_req;
  logic          hit;
  logic          stall;
  logic          age_tick;
  logic [15:0]   miss_cnt;

  int            vectors = 0;
  int            miscompares = 0;
  logic [15:0]   exp_cnt = '0;

  dcache_fill_ctrl #(
    .NLINES   (NL),
    .TTLBITS  (TW),
    .AGEPERIOD(AP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dcache_rdreq(rd),
    .dcache_wrreq(wr),
    .line_miss   (line_miss),
    .line_ttl    (ttl),
    .line_busy   (busy),
    .fill_req    (fill_req),
    .cache_hit   (hit),
    .cache_stall (stall),
    .age_tick    (age_tick),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  // Victim = first line holding the minimum TTL value.
  function automatic int ref_victim(input logic [NL*TW-1:0] t);
    int vals[NL];
    int minv;
    for (int i = 0; i < NL; i++) vals[i] = int'(t[i*TW +: TW]);
    minv = vals[0];
    foreach (vals[i]) if (vals[i] < minv) minv = vals[i];
    for (int i = 0; i < NL; i++) if (vals[i] == minv) return i;
    return 0;
  endfunction

  task automatic rand_req();
    logic [1:0] r;
    r  = 2'($urandom_range(1, 3));
    rd = r[0];
    wr = r[1];
  endtask

  // One full miss: line answers with busy d cycles after the first grant,
  // holding it for blen cycles. Unanswered grants repeat every 16 cycles.
  task automatic do_miss(input logic [NL*TW-1:0] t, input int d, input int blen, input bit drop);
    int v, s;
    logic [NL-1:0] exp_fill;
    v = ref_victim(t);
    s = 2 + d;
    ttl = t;
    line_miss = '1;
    rand_req();
    for (int c = 0; c <= s + blen + 1; c++) begin
      if (c == 1 && drop) begin rd = 1'b0; wr = 1'b0; end
      if (c == s + blen) begin rd = 1'b0; wr = 1'b0; end
      busy = NL'($urandom) & ~(NL'(1) << v);
      if (c >= s && c < s + blen) busy[v] = 1'b1;
      #1;
      if (c == s + blen + 1) begin
        exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
        vectors++;
        if (miss_cnt !== exp_cnt) begin
          miscompares++;
          $display("FAIL miss_cnt_done: got %h expected %h", miss_cnt, exp_cnt);
        end
        vectors++;
        if (stall !== 1'b0 || hit !== 1'b0 || fill_req !== '0) begin
          miscompares++;
          $display("FAIL idle_after_fill: stall/hit/fill got %b/%b/%b expected 0/0/0", stall, hit, fill_req);
        end
      end else begin
        exp_fill = (c >= 2 && c < s && ((c - 2) % 16) == 0) ? (NL'(1) << v) : '0;
        vectors++;
        if (fill_req !== exp_fill) begin
          miscompares++;
          $display("FAIL fill_req c=%0d: got %b expected %b", c, fill_req, exp_fill);
        end
        vectors++;
        if (stall !== 1'b1 || hit !== 1'b0 || miss_cnt !== exp_cnt) begin
          miscompares++;
          $display("FAIL busy_phase c=%0d: stall/hit/cnt got %b/%b/%h expected 1/0/%h", c, stall, hit, miss_cnt, exp_cnt);
        end
      end
      @(negedge clk);
    end
    busy = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rd = 1'b0; wr = 1'b0; line_miss = '0; busy = '0;
    #1;
    vectors++;
    if (fill_req !== '0 || age_tick !== 1'b0 || miss_cnt !== 16'h0 || stall !== 1'b0 || hit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_vals: fill/age/cnt/stall/hit got %b/%b/%h/%b/%b expected 0/0/0/0/0", fill_req, age_tick, miss_cnt, stall, hit);
    end
    rd = 1'b1; line_miss = '1;
    #1;
    vectors++;
    if (stall !== 1'b1 || hit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_comb_stall: stall/hit got %b/%b expected 1/0", stall, hit);
    end
    rd = 1'b0; line_miss = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_hit();
    logic [NL-1:0] m;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) begin
        m = 4'b1011; rd = 1'b1; wr = 1'b0;
      end else begin
        m = NL'($urandom);
        if (m == '1) m[$urandom_range(0, NL-1)] = 1'b0;
        rand_req();
      end
      line_miss = m;
      #1;
      vectors++;
      if (hit !== 1'b1 || stall !== 1'b0 || fill_req !== '0) begin
        miscompares++;
        $display("FAIL hit k=%0d: hit/stall/fill got %b/%b/%b expected 1/0/0", k, hit, stall, fill_req);
      end
      @(negedge clk);
    end
    rd = 1'b0; wr = 1'b0;
    #1;
    vectors++;
    if (hit !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL no_req: hit/stall got %b/%b expected 0/0", hit, stall);
    end
    @(negedge clk);
  endtask

  task automatic test_victim();
    do_miss({8'd90, 8'd17, 8'd17, 8'd200}, 1, 3, 1'b0);
  endtask

  task automatic test_random_miss();
    logic [NL*TW-1:0] t;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NL; i++)
        t[i*TW +: TW] = (k % 2 == 0) ? TW'($urandom_range(0, 7)) : TW'($urandom);
      do_miss(t, int'($urandom_range(1, 5)), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_timeout();
    logic [NL*TW-1:0] t;
    t = NL*TW'($urandom);
    do_miss(t, 18, 2, 1'b0);
  endtask

  task automatic test_saturation();
    force dut.miss_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.miss_cnt_q;
    exp_cnt = 16'hFFFE;
    #1;
    vectors++;
    if (miss_cnt !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL preload: got %h expected fffe", miss_cnt);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      do_miss(NL*TW'($urandom), int'($urandom_range(1, 3)), 1, 1'b0);
  endtask

  task automatic test_reset_mid_and_aging();
    int v;
    ttl = NL*TW'($urandom);
    v = ref_victim(ttl);
    line_miss = '1;
    rd = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c >= 3) busy[v] = 1'b1;
      @(negedge clk);
    end
    #1;
    reset_n = 1'b0;
    rd = 1'b0; wr = 1'b0; busy = '0;
    #1;
    vectors++;
    if (fill_req !== '0 || age_tick !== 1'b0 || miss_cnt !== 16'h0 || stall !== 1'b0 || hit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: fill/age/cnt/stall/hit got %b/%b/%h/%b/%b expected 0/0/0/0/0", fill_req, age_tick, miss_cnt, stall, hit);
    end
    exp_cnt = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3 * AP + 4; c++) begin
      #1;
      vectors++;
      if (age_tick !== ((c % AP) == AP - 1)) begin
        miscompares++;
        $display("FAIL age_tick c=%0d: got %b expected %b", c, age_tick, (c % AP) == AP - 1);
      end
      vectors++;
      if (fill_req !== '0 || stall !== 1'b0 || miss_cnt !== exp_cnt) begin
        miscompares++;
        $display("FAIL post_reset c=%0d: fill/stall/cnt got %b/%b/%h expected 0/0/0", c, fill_req, stall, miss_cnt);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_hit();
    test_victim();
    test_random_miss();
    test_timeout();
    test_saturation();
    test_reset_mid_and_aging();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
